captura_clave_teclado: RTL and testbench

Upstream stage of the parking access controller: it assembles single keypad presses into the 16-bit BCD PIN `clave` consumed by the access FSM. It accepts keys only while a vehicle is present. It issues a one-cycle `clave_valida` strobe when a complete 4-digit PIN is submitted with '#'. Partial entries are discarded on '*', on inactivity timeout, or when the vehicle leaves.

---
 rtl/clave_pkg.sv | 21 ++
 rtl/temporizador_inactividad.sv | 29 ++
 rtl/captura_clave_teclado.sv | 123 ++++++++++++
 tb/tb_captura_clave_teclado.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/clave_pkg.sv
// Shared key codes, FSM state encoding and PIN geometry for the keypad PIN capture path.
// Imported by the capture top and its inactivity timer.
package clave_pkg;

  localparam int N_DIGITOS_DEF = 4;

  localparam logic [3:0] TECLA_MAX_DIGITO = 4'h9;
  localparam logic [3:0] TECLA_BORRAR     = 4'hA;
  localparam logic [3:0] TECLA_ENVIAR     = 4'hB;

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    CAPTURA  = 2'd1,
    LLENO    = 2'd2
  } estado_t;

  function automatic logic es_digito(input logic [3:0] codigo);
    return codigo <= TECLA_MAX_DIGITO;
  endfunction

endpackage

// File: rtl/temporizador_inactividad.sv
// Idle counter for partial PIN entries; expira is combinational, high in the cycle before count T-1.
// Latency: expira asserts TIMEOUT_CICLOS-2 cycles after the last clear; no backpressure.
module temporizador_inactividad #(
  parameter int TIMEOUT_CICLOS = 1000,
  parameter int ANCHO_TIMEOUT  = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic limpiar,
  input  logic habilitar_cuenta,
  output logic expira
);

  logic [ANCHO_TIMEOUT-1:0] cuenta;

  // Held at zero whenever counting is disabled, so an empty buffer never ages.
  always_ff @(posedge clock) begin
    if (reset || limpiar || !habilitar_cuenta) begin
      cuenta <= '0;
    end else begin
      cuenta <= cuenta + ANCHO_TIMEOUT'(1);
    end
  end

  // Fires while the next edge would take the count to TIMEOUT_CICLOS-1, so the
  // registered strobe lands exactly TIMEOUT_CICLOS-1 cycles after the key edge.
  assign expira = habilitar_cuenta && (cuenta == ANCHO_TIMEOUT'(TIMEOUT_CICLOS - 2));

endmodule

// File: rtl/captura_clave_teclado.sv
// Assembles keypad digits into a BCD PIN, submitted with '#', while a vehicle is present.
// Latency: all outputs registered, 1 cycle after the key edge; keys are strobes, no backpressure.
module captura_clave_teclado
  import clave_pkg::*;
#(
  parameter int N_DIGITOS      = N_DIGITOS_DEF,
  parameter int TIMEOUT_CICLOS = 1000,
  parameter int ANCHO_TIMEOUT  = 10,
  localparam int ANCHO_CLAVE   = 4 * N_DIGITOS,
  localparam int ANCHO_CNT     = $clog2(N_DIGITOS + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   habilitar,
  input  logic                   tecla_pulso,
  input  logic [3:0]             tecla_codigo,
  output logic [ANCHO_CLAVE-1:0] clave,
  output logic                   clave_valida,
  output logic [ANCHO_CNT-1:0]   digitos_cnt,
  output logic                   error_formato,
  output logic                   timeout_entrada
);

  estado_t                estado, estado_sig;
  logic [ANCHO_CLAVE-1:0] buffer, buffer_sig, clave_sig;
  logic [ANCHO_CNT-1:0]   cnt_sig;
  logic                   valida_sig, error_sig, timeout_sig;
  logic                   tecla_aceptada, expira;

  temporizador_inactividad #(
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS),
    .ANCHO_TIMEOUT  (ANCHO_TIMEOUT)
  ) u_temporizador (
    .clock            (clock),
    .reset            (reset),
    .limpiar          (tecla_aceptada || !habilitar || timeout_sig),
    .habilitar_cuenta (digitos_cnt != '0),
    .expira           (expira)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado          <= INACTIVO;
      buffer          <= '0;
      digitos_cnt     <= '0;
      clave           <= '0;
      clave_valida    <= 1'b0;
      error_formato   <= 1'b0;
      timeout_entrada <= 1'b0;
    end else begin
      estado          <= estado_sig;
      buffer          <= buffer_sig;
      digitos_cnt     <= cnt_sig;
      clave           <= clave_sig;
      clave_valida    <= valida_sig;
      error_formato   <= error_sig;
      timeout_entrada <= timeout_sig;
    end
  end

  always_comb begin
    estado_sig     = estado;
    buffer_sig     = buffer;
    cnt_sig        = digitos_cnt;
    clave_sig      = clave;
    valida_sig     = 1'b0;
    error_sig      = 1'b0;
    timeout_sig    = 1'b0;
    tecla_aceptada = 1'b0;

    // Vehicle leaving overrides everything, including a '#' in the same cycle.
    if (!habilitar) begin
      estado_sig = INACTIVO;
      buffer_sig = '0;
      cnt_sig    = '0;
    end else begin
      case (estado)
        INACTIVO: begin
          estado_sig = CAPTURA;
          buffer_sig = '0;
          cnt_sig    = '0;
        end
        CAPTURA, LLENO: begin
          if (tecla_pulso && tecla_codigo == TECLA_BORRAR) begin
            tecla_aceptada = 1'b1;
            estado_sig     = CAPTURA;
            buffer_sig     = '0;
            cnt_sig        = '0;
          end else if (tecla_pulso && tecla_codigo == TECLA_ENVIAR) begin
            tecla_aceptada = 1'b1;
            estado_sig     = CAPTURA;
            buffer_sig     = '0;
            cnt_sig        = '0;
            if (estado == LLENO) begin
              clave_sig  = buffer;
              valida_sig = 1'b1;
            end else begin
              error_sig = 1'b1;
            end
          end else if (tecla_pulso && es_digito(tecla_codigo) && estado == CAPTURA) begin
            tecla_aceptada = 1'b1;
            buffer_sig     = {buffer[ANCHO_CLAVE-5:0], tecla_codigo};
            cnt_sig        = digitos_cnt + ANCHO_CNT'(1);
            if (cnt_sig == ANCHO_CNT'(N_DIGITOS)) begin
              estado_sig = LLENO;
            end
          end else if (expira) begin
            timeout_sig = 1'b1;
            estado_sig  = CAPTURA;
            buffer_sig  = '0;
            cnt_sig     = '0;
          end
        end
        default: begin
          estado_sig = INACTIVO;
          buffer_sig = '0;
          cnt_sig    = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_captura_clave_teclado.sv
// Directed bench for captura_clave_teclado: per-cycle vector table plus timeout and reset sequences.
module tb_captura_clave_teclado;

  localparam int T = 1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        habilitar;
  logic        tecla_pulso;
  logic [3:0]  tecla_codigo;
  logic [15:0] clave;
  logic        clave_valida;
  logic [2:0]  digitos_cnt;
  logic        error_formato;
  logic        timeout_entrada;

  int checks = 0;
  int errors = 0;

  captura_clave_teclado #(
    .N_DIGITOS      (4),
    .TIMEOUT_CICLOS (T),
    .ANCHO_TIMEOUT  (10)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .habilitar       (habilitar),
    .tecla_pulso     (tecla_pulso),
    .tecla_codigo    (tecla_codigo),
    .clave           (clave),
    .clave_valida    (clave_valida),
    .digitos_cnt     (digitos_cnt),
    .error_formato   (error_formato),
    .timeout_entrada (timeout_entrada)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        hab;
    logic        pulso;
    logic [3:0]  cod;
    logic [15:0] clave;
    logic        val;
    logic [2:0]  cnt;
    logic        err;
    logic        to;
  } vec_t;

  vec_t tabla[$];

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nombre, act, req);
    end
  endtask

  task automatic add(input logic h, input logic p, input logic [3:0] c, input logic [15:0] cl,
                     input logic v, input logic [2:0] n, input logic e, input logic t);
    vec_t x;
    x.hab = h; x.pulso = p; x.cod = c; x.clave = cl; x.val = v; x.cnt = n; x.err = e; x.to = t;
    tabla.push_back(x);
  endtask

  // One key cycle followed by one idle cycle in which strobes have dropped.
  task automatic k(input logic [3:0] c, input logic [15:0] cl, input logic v,
                   input logic [2:0] n, input logic e);
    add(1'b1, 1'b1, c, cl, v, n, e, 1'b0);
    add(1'b1, 1'b0, 4'h0, cl, 1'b0, n, 1'b0, 1'b0);
  endtask

  task automatic paso(input logic h, input logic p, input logic [3:0] c);
    habilitar = h; tecla_pulso = p; tecla_codigo = c;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_todo(input string n, input logic [15:0] cl, input logic v,
                          input logic [2:0] cnt, input logic e, input logic t);
    chk({n, " clave"}, 32'(clave), 32'(cl));
    chk({n, " clave_valida"}, 32'(clave_valida), 32'(v));
    chk({n, " digitos_cnt"}, 32'(digitos_cnt), 32'(cnt));
    chk({n, " error_formato"}, 32'(error_formato), 32'(e));
    chk({n, " timeout_entrada"}, 32'(timeout_entrada), 32'(t));
  endtask

  initial begin
    int primer_j;
    int pulsos;

    // Enter CAPTURA, then 3,2,5,7,'#'
    add(1, 0, 4'h0, 16'h0000, 0, 0, 0, 0);
    k(4'h3, 16'h0000, 0, 1, 0); k(4'h2, 16'h0000, 0, 2, 0);
    k(4'h5, 16'h0000, 0, 3, 0); k(4'h7, 16'h0000, 0, 4, 0);
    k(4'hB, 16'h3257, 1, 0, 0);
    // Short entry: 7,5,'#'
    k(4'h7, 16'h3257, 0, 1, 0); k(4'h5, 16'h3257, 0, 2, 0);
    k(4'hB, 16'h3257, 0, 0, 1);
    // Reserved code and fifth digit ignored
    k(4'h4, 16'h3257, 0, 1, 0); k(4'hC, 16'h3257, 0, 1, 0);
    k(4'h3, 16'h3257, 0, 2, 0); k(4'h6, 16'h3257, 0, 3, 0);
    k(4'h8, 16'h3257, 0, 4, 0); k(4'h9, 16'h3257, 0, 4, 0);
    k(4'hB, 16'h4368, 1, 0, 0);
    // Erase mid-entry
    k(4'h2, 16'h4368, 0, 1, 0); k(4'h6, 16'h4368, 0, 2, 0);
    k(4'hA, 16'h4368, 0, 0, 0);
    k(4'h3, 16'h4368, 0, 1, 0); k(4'h2, 16'h4368, 0, 2, 0);
    k(4'h5, 16'h4368, 0, 3, 0); k(4'h7, 16'h4368, 0, 4, 0);
    k(4'hB, 16'h3257, 1, 0, 0);
    // Vehicle leaves mid-entry; keys while disabled and on the re-entry cycle ignored
    k(4'h3, 16'h3257, 0, 1, 0); k(4'h2, 16'h3257, 0, 2, 0); k(4'h5, 16'h3257, 0, 3, 0);
    add(0, 0, 4'h0, 16'h3257, 0, 0, 0, 0);
    add(0, 1, 4'h1, 16'h3257, 0, 0, 0, 0);
    add(0, 1, 4'hB, 16'h3257, 0, 0, 0, 0);
    add(1, 1, 4'h8, 16'h3257, 0, 0, 0, 0);
    k(4'h5, 16'h3257, 0, 1, 0); k(4'h4, 16'h3257, 0, 2, 0);
    k(4'h7, 16'h3257, 0, 3, 0); k(4'h9, 16'h3257, 0, 4, 0);
    k(4'hB, 16'h5479, 1, 0, 0);
    // '#' while full coinciding with habilitar falling
    k(4'h1, 16'h5479, 0, 1, 0); k(4'h2, 16'h5479, 0, 2, 0);
    k(4'h3, 16'h5479, 0, 3, 0); k(4'h4, 16'h5479, 0, 4, 0);
    add(0, 1, 4'hB, 16'h5479, 0, 0, 0, 0);
    add(1, 0, 4'h0, 16'h5479, 0, 0, 0, 0);

    reset = 1'b1; habilitar = 1'b0; tecla_pulso = 1'b0; tecla_codigo = 4'h0;
    repeat (2) @(posedge clock);
    #1;
    chk_todo("reset", 16'h0000, 0, 0, 0, 0);
    reset = 1'b0;

    foreach (tabla[i]) begin
      paso(tabla[i].hab, tabla[i].pulso, tabla[i].cod);
      chk_todo($sformatf("vec%0d", i), tabla[i].clave, tabla[i].val, tabla[i].cnt,
               tabla[i].err, tabla[i].to);
    end

    // Inactivity timeout: pulse exactly T-1 cycles after the key edge
    paso(1, 1, 4'h1);
    chk("to key cnt", 32'(digitos_cnt), 32'd1);
    primer_j = -1;
    pulsos   = 0;
    for (int j = 1; j <= T + 4; j++) begin
      paso(1, 0, 4'h0);
      if (timeout_entrada) begin
        pulsos++;
        if (primer_j < 0) primer_j = j;
      end
    end
    chk("to position", 32'(primer_j), 32'(T - 1));
    chk("to pulses", 32'(pulsos), 32'd1);
    chk("to cnt after", 32'(digitos_cnt), 32'd0);
    chk("to clave kept", 32'(clave), 32'h5479);

    // Key on the expiry cycle suppresses the timeout
    paso(1, 1, 4'h1);
    for (int j = 1; j <= T - 2; j++) paso(1, 0, 4'h0);
    paso(1, 1, 4'h2);
    chk("to suppressed", 32'(timeout_entrada), 32'd0);
    chk("to suppressed cnt", 32'(digitos_cnt), 32'd2);
    paso(1, 1, 4'hA);
    chk("erase after suppress", 32'(digitos_cnt), 32'd0);

    // Reset mid-entry
    paso(1, 1, 4'h3);
    paso(1, 1, 4'h2);
    chk("pre-reset cnt", 32'(digitos_cnt), 32'd2);
    reset = 1'b1;
    paso(1, 1, 4'h5);
    chk_todo("mid reset", 16'h0000, 0, 0, 0, 0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
